// File: rtl/instruction_fetch.sv
// Purpose: PC generation and IF/ID pipeline register feeding decode.
// Latency: the instruction at PC P reaches if_id_* one edge after pc = P; one instruction per cycle.
// Backpressure: stall freezes pc and IF/ID. A redirect overrides stall and leaves one bubble.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   stall             hazard hold; freezes pc and all IF/ID fields
//   redirect_en/_pc   taken branch/jump from execute; low two target bits are dropped
//   imem_addr         combinational instruction-memory address (equals pc)
//   imem_instruction  combinational read data for imem_addr
//   if_id_*           registered IF/ID slot: pc, pc+4, instruction, valid
//   fetch_fault       registered; the captured pc lies in the data half (MSB set)
module instruction_fetch #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_instruction,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc_plus4,
  output logic [XLEN-1:0] if_id_instruction,
  output logic            if_id_valid,
  output logic            fetch_fault
);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            pc_fault;

  // Sequential successor wraps naturally at 2^XLEN.
  assign pc_plus4  = pc + XLEN'(4);
  // The upper half of the address space holds data, never instructions.
  assign pc_fault  = pc[XLEN-1];
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc                <= RESET_PC;
      if_id_pc          <= '0;
      if_id_pc_plus4    <= '0;
      if_id_instruction <= NOP_INSTR;
      if_id_valid       <= 1'b0;
      fetch_fault       <= 1'b0;
    end else if (redirect_en) begin
      // Whatever sits in IF/ID (stalled or not) is wrong-path, so flush it.
      // The slot's pc fields keep their old values; they are meaningless while invalid.
      pc                <= redirect_pc & ~XLEN'(3);
      if_id_instruction <= NOP_INSTR;
      if_id_valid       <= 1'b0;
      fetch_fault       <= 1'b0;
    end else if (!stall) begin
      pc                <= pc_plus4;
      if_id_pc          <= pc;
      if_id_pc_plus4    <= pc_plus4;
      // A faulting fetch still records its pc for the exception path,
      // but never hands a real instruction to decode.
      if_id_instruction <= pc_fault ? NOP_INSTR : imem_instruction;
      if_id_valid       <= ~pc_fault;
      fetch_fault       <= pc_fault;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_instruction;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic [31:0] if_id_instruction;
  logic        if_id_valid;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;

  instruction_fetch #(
    .XLEN(32), .RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_instruction(imem_instruction),
    .if_id_pc(if_id_pc), .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_instruction(if_id_instruction), .if_id_valid(if_id_valid),
    .fetch_fault(fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: the four preloaded words, then an address-derived pattern.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0: return 32'h0050_0093;
      32'h4: return 32'h00A0_0113;
      32'h8: return 32'h0020_81B3;
      32'hC: return 32'h0000_0013;
      default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0003;
    endcase
  endfunction

  assign imem_instruction = mem_word(imem_addr);

  // Reference model: architectural view of fetch, updated once per clock edge.
  logic [31:0] m_pc, m_ipc, m_ip4, m_instr;
  logic        m_valid, m_fault;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic s, input logic re, input logic [31:0] rp);
    logic [31:0] cur;
    cur = m_pc;
    if (r) begin
      m_pc = 32'h0; m_ipc = 32'h0; m_ip4 = 32'h0;
      m_instr = NOP; m_valid = 1'b0; m_fault = 1'b0;
    end else if (re) begin
      m_pc = (rp / 4) * 4;
      m_instr = NOP; m_valid = 1'b0; m_fault = 1'b0;
    end else if (!s) begin
      m_ipc   = cur;
      m_ip4   = cur + 32'd4;
      m_fault = (cur >= 32'h8000_0000);
      m_valid = !m_fault;
      m_instr = m_fault ? NOP : mem_word(cur);
      m_pc    = cur + 32'd4;
    end
  endtask

  // Apply one cycle of inputs, advance the model, and compare every output with it.
  task automatic step(input logic r, input logic s, input logic re, input logic [31:0] rp);
    rst = r; stall = s; redirect_en = re; redirect_pc = rp;
    @(posedge clk);
    model_edge(r, s, re, rp);
    #1;
    chk("model.imem_addr", imem_addr, m_pc);
    chk("model.valid", {31'b0, if_id_valid}, {31'b0, m_valid});
    chk("model.fault", {31'b0, fetch_fault}, {31'b0, m_fault});
    chk("model.instr", if_id_instruction, m_instr);
    chk("model.pc", if_id_pc, m_ipc);
    chk("model.pc_plus4", if_id_pc_plus4, m_ip4);
  endtask

  typedef struct {
    logic        r, s, re;
    logic [31:0] rp;
    logic [31:0] e_addr;
    logic        chkpc;
    logic [31:0] e_pc, e_p4, e_instr;
    logic        e_valid, e_fault;
  } vec_t;

  vec_t v[$];

  task automatic add(input logic r, input logic s, input logic re, input logic [31:0] rp,
                     input logic [31:0] ea, input logic cp, input logic [31:0] ep,
                     input logic [31:0] e4, input logic [31:0] ei, input logic ev, input logic ef);
    vec_t t;
    t.r = r; t.s = s; t.re = re; t.rp = rp; t.e_addr = ea; t.chkpc = cp;
    t.e_pc = ep; t.e_p4 = e4; t.e_instr = ei; t.e_valid = ev; t.e_fault = ef;
    v.push_back(t);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
    m_pc = '0; m_ipc = '0; m_ip4 = '0; m_instr = NOP; m_valid = 1'b0; m_fault = 1'b0;

    //   r  s  re rp            addr          cp pc            pc+4          instr             v  f
    // Reset and free run through the preloaded words, with a 3-cycle stall at pc = 8.
    add(1, 0, 0, 32'h0,        32'h0,        1, 32'h0,        32'h0,        NOP,              0, 0);
    add(0, 0, 0, 32'h0,        32'h4,        1, 32'h0,        32'h4,        32'h0050_0093,    1, 0);
    add(0, 0, 0, 32'h0,        32'h8,        1, 32'h4,        32'h8,        32'h00A0_0113,    1, 0);
    add(0, 1, 0, 32'h0,        32'h8,        1, 32'h4,        32'h8,        32'h00A0_0113,    1, 0);
    add(0, 1, 0, 32'h0,        32'h8,        1, 32'h4,        32'h8,        32'h00A0_0113,    1, 0);
    add(0, 1, 0, 32'h0,        32'h8,        1, 32'h4,        32'h8,        32'h00A0_0113,    1, 0);
    add(0, 0, 0, 32'h0,        32'hC,        1, 32'h8,        32'hC,        32'h0020_81B3,    1, 0);
    add(0, 0, 0, 32'h0,        32'h10,       1, 32'hC,        32'h10,       32'h0000_0013,    1, 0);
    // Unaligned redirect at pc = 0x10: one bubble, then the target.
    add(0, 0, 1, 32'h103,      32'h100,      0, 32'h0,        32'h0,        NOP,              0, 0);
    add(0, 0, 0, 32'h0,        32'h104,      1, 32'h100,      32'h104,      mem_word(32'h100), 1, 0);
    // Redirect and stall together at pc = 0x20: redirect wins.
    add(0, 0, 1, 32'h20,       32'h20,       0, 32'h0,        32'h0,        NOP,              0, 0);
    add(0, 1, 1, 32'h40,       32'h40,       0, 32'h0,        32'h0,        NOP,              0, 0);
    add(0, 0, 0, 32'h0,        32'h44,       1, 32'h40,       32'h44,       mem_word(32'h40), 1, 0);
    // Fetch from the data half faults; redirect to 0 clears it.
    add(0, 0, 1, 32'h8000_0000, 32'h8000_0000, 0, 32'h0,      32'h0,        NOP,              0, 0);
    add(0, 0, 0, 32'h0,        32'h8000_0004, 1, 32'h8000_0000, 32'h8000_0004, NOP,          0, 1);
    add(0, 0, 1, 32'h0,        32'h0,        0, 32'h0,        32'h0,        NOP,              0, 0);
    add(0, 0, 0, 32'h0,        32'h4,        1, 32'h0,        32'h4,        32'h0050_0093,    1, 0);
    // Last legal word, then the first faulting one.
    add(0, 0, 1, 32'h7FFF_FFFC, 32'h7FFF_FFFC, 0, 32'h0,      32'h0,        NOP,              0, 0);
    add(0, 0, 0, 32'h0,        32'h8000_0000, 1, 32'h7FFF_FFFC, 32'h8000_0000, mem_word(32'h7FFF_FFFC), 1, 0);
    add(0, 0, 0, 32'h0,        32'h8000_0004, 1, 32'h8000_0000, 32'h8000_0004, NOP,          0, 1);
    // PC wrap at the top of the address space.
    add(0, 0, 1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 0, 32'h0,      32'h0,        NOP,              0, 0);
    add(0, 0, 0, 32'h0,        32'h0,        1, 32'hFFFF_FFFC, 32'h0,       NOP,              0, 1);
    add(0, 0, 0, 32'h0,        32'h4,        1, 32'h0,        32'h4,        32'h0050_0093,    1, 0);
    // Reset during a stall discards the slot.
    add(0, 1, 0, 32'h0,        32'h4,        1, 32'h0,        32'h4,        32'h0050_0093,    1, 0);
    add(1, 1, 1, 32'h200,      32'h0,        1, 32'h0,        32'h0,        NOP,              0, 0);

    foreach (v[i]) begin
      step(v[i].r, v[i].s, v[i].re, v[i].rp);
      chk($sformatf("vec%0d.imem_addr", i), imem_addr, v[i].e_addr);
      chk($sformatf("vec%0d.valid", i), {31'b0, if_id_valid}, {31'b0, v[i].e_valid});
      chk($sformatf("vec%0d.fault", i), {31'b0, fetch_fault}, {31'b0, v[i].e_fault});
      chk($sformatf("vec%0d.instr", i), if_id_instruction, v[i].e_instr);
      if (v[i].chkpc) begin
        chk($sformatf("vec%0d.pc", i), if_id_pc, v[i].e_pc);
        chk($sformatf("vec%0d.pc_plus4", i), if_id_pc_plus4, v[i].e_p4);
      end
    end

    // Randomized traffic against the model, including unaligned and data-half targets.
    for (int n = 0; n < 400; n++) begin
      logic        r, s, re;
      logic [31:0] rp;
      r  = ($urandom_range(0, 49) == 0);
      s  = ($urandom_range(0, 3) == 0);
      re = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 3))
        0: rp = $urandom;
        1: rp = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        2: rp = 32'h7FFF_FFF0 | ($urandom & 32'hF);
        default: rp = $urandom & 32'h0000_03FF;
      endcase
      step(r, s, re, rp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
